// File: rtl/mem_wb_pipe_pkg.sv
// Shared core definitions for the MEM->WB stage: load-size encodings and stage occupancy states.
package mem_wb_pipe_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    LS_BYTE  = 2'd0,
    LS_HALF  = 2'd1,
    LS_WORD  = 2'd2,
    LS_DWORD = 2'd3
  } ld_size_e;

  // Occupancy of the main/skid entry pair; (main empty, skid full) cannot occur.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } occ_e;

endpackage

// File: rtl/mem_wb_if.sv
// MEM->WB stage channel: upstream MEM request fields plus the downstream writeback handshake.
interface mem_wb_if
  import mem_wb_pipe_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEFAULT,
  parameter int unsigned REG_AW = 5
);
  localparam int unsigned OffW = $clog2(XLEN / 8);

  logic              in_valid;
  logic              in_ready;
  logic              in_rd_we;
  logic [REG_AW-1:0] in_rd_waddr;
  logic [XLEN-1:0]   in_rd_data;
  logic              in_is_load;
  logic [1:0]        in_ld_size;
  logic              in_ld_uns;
  logic [OffW-1:0]   in_ld_off;
  logic [XLEN-1:0]   in_ld_word;

  logic              out_valid;
  logic              out_ready;
  logic              out_rd_we;
  logic [REG_AW-1:0] out_rd_waddr;
  logic [XLEN-1:0]   out_rd_data;

  // Environment around the stage: drives MEM requests and WB acceptance.
  modport master (
    output in_valid, in_rd_we, in_rd_waddr, in_rd_data, in_is_load, in_ld_size, in_ld_uns,
           in_ld_off, in_ld_word, out_ready,
    input  in_ready, out_valid, out_rd_we, out_rd_waddr, out_rd_data
  );

  // The pipeline stage itself.
  modport slave (
    input  in_valid, in_rd_we, in_rd_waddr, in_rd_data, in_is_load, in_ld_size, in_ld_uns,
           in_ld_off, in_ld_word, out_ready,
    output in_ready, out_valid, out_rd_we, out_rd_waddr, out_rd_data
  );

endinterface

// File: rtl/dff.sv
// Enabled payload register with asynchronous active-low clear.
module dff #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/mem_wb_pipe_load_ext.sv
// Load-data extraction: shift the addressed field down, truncate to size, sign/zero-extend.
module mem_wb_pipe_load_ext
  import mem_wb_pipe_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT,
  parameter int unsigned OffW = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0] ld_word_i,
  input  logic [OffW-1:0] ld_off_i,
  input  logic [1:0]      ld_size_i,
  input  logic            ld_uns_i,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] ext_b;
  logic [XLEN-1:0] ext_h;
  logic [XLEN-1:0] ext_w;
  logic            sign_b;
  logic            sign_h;

  assign shifted = ld_word_i >> {ld_off_i, 3'b000};
  assign sign_b  = !ld_uns_i && shifted[7];
  assign sign_h  = !ld_uns_i && shifted[15];
  assign ext_b   = {{(XLEN - 8){sign_b}}, shifted[7:0]};
  assign ext_h   = {{(XLEN - 16){sign_h}}, shifted[15:0]};

  if (XLEN > 32) begin : g_word_ext
    logic sign_w;
    assign sign_w = !ld_uns_i && shifted[31];
    assign ext_w  = {{(XLEN - 32){sign_w}}, shifted[31:0]};
  end else begin : g_word_full
    assign ext_w = shifted;
  end

  always_comb begin
    data_o = ext_w;
    unique case (ld_size_e'(ld_size_i))
      LS_BYTE:  data_o = ext_b;
      LS_HALF:  data_o = ext_h;
      LS_WORD:  data_o = ext_w;
      // A dword on a 32-bit core degenerates to a word.
      LS_DWORD: data_o = (XLEN > 32) ? shifted : ext_w;
    endcase
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline stage: valid/ready with a 2-entry skid buffer, flush, x0 write guard, load extract.
module mem_wb_pipe
  import mem_wb_pipe_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEFAULT,
  parameter int unsigned REG_AW     = 5,
  parameter bit          ZERO_GUARD = 1'b1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  mem_wb_if.slave   bus
);

  localparam int unsigned OffW = $clog2(XLEN / 8);
  localparam int unsigned PayW = 1 + REG_AW + XLEN;

  occ_e            state_q, state_d;
  logic            main_v;
  logic            accept;
  logic            retire;
  logic            main_en;
  logic            main_from_skid;
  logic            skid_en;
  logic            fmt_we;
  logic [XLEN-1:0] ld_data;
  logic [XLEN-1:0] fmt_data;
  logic [PayW-1:0] fmt_pay;
  logic [PayW-1:0] main_d;
  logic [PayW-1:0] main_q;
  logic [PayW-1:0] skid_q;

  mem_wb_pipe_load_ext #(
    .XLEN (XLEN),
    .OffW (OffW)
  ) u_load_ext (
    .ld_word_i (bus.in_ld_word),
    .ld_off_i  (bus.in_ld_off),
    .ld_size_i (bus.in_ld_size),
    .ld_uns_i  (bus.in_ld_uns),
    .data_o    (ld_data)
  );

  assign fmt_data = bus.in_is_load ? ld_data : bus.in_rd_data;
  assign fmt_we   = bus.in_rd_we && !(ZERO_GUARD && (bus.in_rd_waddr == '0));
  assign fmt_pay  = {fmt_we, bus.in_rd_waddr, fmt_data};

  assign main_v       = (state_q != StEmpty);
  assign bus.in_ready = (state_q != StFull);
  assign accept       = bus.in_valid && bus.in_ready;
  assign retire       = main_v && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    main_from_skid = 1'b0;
    skid_en        = 1'b0;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d = StOne;
            main_en = 1'b1;
          end
        end
        StOne: begin
          if (retire && accept) begin
            main_en = 1'b1;
          end else if (retire) begin
            state_d = StEmpty;
          end else if (accept) begin
            state_d = StFull;
            skid_en = 1'b1;
          end
        end
        StFull: begin
          // in_ready is low here, so only a retire can happen; skid is promoted.
          if (retire) begin
            state_d        = StOne;
            main_en        = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_q : fmt_pay;

  dff #(
    .Width (PayW)
  ) u_main_reg (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (main_en),
    .d_i    (main_d),
    .q_o    (main_q)
  );

  dff #(
    .Width (PayW)
  ) u_skid_reg (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (skid_en),
    .d_i    (fmt_pay),
    .q_o    (skid_q)
  );

  assign bus.out_valid    = main_v;
  assign bus.out_rd_we    = main_v && main_q[PayW-1];
  assign bus.out_rd_waddr = main_q[XLEN +: REG_AW];
  assign bus.out_rd_data  = main_q[XLEN-1:0];

endmodule
